// File: rtl/ffo32s_pkg.sv
// Shared definitions for the sequential 32-bit find-first-one scanner/generator pair.
// Bit ordering is [0:31]: index 0 is the first bit the scanner examines.
package ffo32s_pkg;

    localparam int WIDTH = 32;
    localparam int POS_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } ffo_state_t;

endpackage

// File: rtl/ffo32s_genbit.sv
// Inserted-bit select for the first-one generator: zeros before p, a one at p, then tail or zeros.
// The tail input exists only when FFO32S_GEN_TAIL_EN is defined.
module ffo32s_genbit
    import ffo32s_pkg::*;
(
    input  logic             v,
    input  logic [0:POS_W-1] p,
`ifdef FFO32S_GEN_TAIL_EN
    input  logic [0:WIDTH-1] tail,
`endif
    input  logic [POS_W-1:0] count,
    output logic             bit_in
);

    always_comb begin
        bit_in = 1'b0;
        if (v) begin
            if (count == p) begin
                bit_in = 1'b1;
            end
`ifdef FFO32S_GEN_TAIL_EN
            else if (count > p) begin
                bit_in = tail[count];
            end
`endif
        end
    end

endmodule

// File: rtl/ffo32s_gen.sv
// Sequential first-one vector generator: builds b[0:31] one bit per clock from a (v, p) pair.
// Optional FFO32S_GEN_TAIL_EN adds a tail port that fills the bits after p.
module ffo32s_gen #(
    parameter int WIDTH = 32,
    parameter int POS_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             v,
    input  logic [0:POS_W-1] p,
`ifdef FFO32S_GEN_TAIL_EN
    input  logic [0:WIDTH-1] tail,
`endif
    output logic [0:WIDTH-1] b,
    output logic             ready,
    output logic             done
);
    import ffo32s_pkg::*;

    ffo_state_t       state, state_nxt;
    logic [POS_W-1:0] count, count_nxt;
    logic [0:WIDTH-1] sr, sr_nxt;
    logic             done_q, done_nxt;
    logic             v_q, v_nxt;
    logic [0:POS_W-1] p_q, p_nxt;
    logic             ins_bit;
`ifdef FFO32S_GEN_TAIL_EN
    logic [0:WIDTH-1] tail_q, tail_nxt;
`endif

    ffo32s_genbit u_genbit (
        .v      (v_q),
        .p      (p_q),
`ifdef FFO32S_GEN_TAIL_EN
        .tail   (tail_q),
`endif
        .count  (count),
        .bit_in (ins_bit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            sr     <= '0;
            done_q <= 1'b0;
            v_q    <= 1'b0;
            p_q    <= '0;
`ifdef FFO32S_GEN_TAIL_EN
            tail_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            sr     <= sr_nxt;
            done_q <= done_nxt;
            v_q    <= v_nxt;
            p_q    <= p_nxt;
`ifdef FFO32S_GEN_TAIL_EN
            tail_q <= tail_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        sr_nxt    = sr;
        done_nxt  = 1'b0;
        v_nxt     = v_q;
        p_nxt     = p_q;
`ifdef FFO32S_GEN_TAIL_EN
        tail_nxt  = tail_q;
`endif
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    v_nxt     = v;
                    p_nxt     = p;
`ifdef FFO32S_GEN_TAIL_EN
                    tail_nxt  = tail;
`endif
                    count_nxt = '0;
                    state_nxt = GEN;
                end
            end
            GEN: begin
                // New bit enters at the b[31] end; the bit from count i settles at b[i].
                sr_nxt = {sr[1:WIDTH-1], ins_bit};
                if (count == POS_W'(WIDTH - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + POS_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign b    = sr;
    assign done = done_q;

endmodule
